// File: rtl/pd_msg_padder_pkg.sv
// Shared constants, sizing helpers and FSM state type for the SHA-256 message padder.
package pd_pkg;

  localparam int PD_BLK_BITS = 512;
  localparam int PD_LEN_BITS = 64;

  typedef enum logic [0:0] {
    PD_IDLE = 1'b0,
    PD_EMIT = 1'b1
  } pd_pad_state_t;

  // Blocks needed for message + '1' bit + 64-bit length.
  function automatic int pd_nblk(input int msg_bits);
    return (msg_bits + PD_LEN_BITS + 1 + PD_BLK_BITS - 1) / PD_BLK_BITS;
  endfunction

  function automatic int pd_idx_w(input int nblk);
    return (nblk <= 2) ? 1 : $clog2(nblk);
  endfunction

endpackage

// File: rtl/pd_word_flip.sv
// Combinational byte reversal inside each 32-bit word (0x01234567 -> 0x67452301).
module pd_word_flip #(
  parameter int WORDS = 1
) (
  input  logic [32*WORDS-1:0] i_data,
  output logic [32*WORDS-1:0] o_data
);

  for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
    assign o_data[32*gi +: 32] = {i_data[32*gi      +: 8],
                                  i_data[32*gi + 8  +: 8],
                                  i_data[32*gi + 16 +: 8],
                                  i_data[32*gi + 24 +: 8]};
  end

endmodule

// File: rtl/pd_msg_padder.sv
// Registers one message and streams its SHA-256 padded image as 512-bit blocks.
// Optional build macro PD_ENDIAN_FLIP_EN byte-reverses each 32-bit message word on load.
module pd_msg_padder
  import pd_pkg::*;
#(
  parameter  int MSG_BITS = 640,
  parameter  int BLK_BITS = 512,
  localparam int NBLK     = pd_nblk(MSG_BITS),
  localparam int IDX_W    = pd_idx_w(NBLK)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   msg_valid,
  output logic                   msg_ready,
  input  logic [MSG_BITS-1:0]    msg_data,
  input  logic [IDX_W-1:0]       start_block,
  output logic                   blk_valid,
  input  logic                   blk_ready,
  output logic [PD_BLK_BITS-1:0] blk_data,
  output logic [IDX_W-1:0]       blk_idx,
  output logic                   blk_last,
  output logic                   busy
);

  localparam int PAD_BITS = NBLK * PD_BLK_BITS;
  localparam int TAIL_W   = PAD_BITS - MSG_BITS - 1;
  localparam int NENT     = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBLK - 1);

  if (BLK_BITS != PD_BLK_BITS) begin : g_bad_blk_bits
    $error("pd_msg_padder: BLK_BITS must be 512");
  end
  if (MSG_BITS < 1 || MSG_BITS > (1 << 20)) begin : g_bad_msg_bits
    $error("pd_msg_padder: MSG_BITS out of range 1..2^20");
  end

  pd_pad_state_t       r_state;
  pd_pad_state_t       w_state_next;
  logic [MSG_BITS-1:0] r_msg;
  logic [MSG_BITS-1:0] w_msg_in;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_next;
  logic [IDX_W-1:0]    w_start_clamped;
  logic                w_load;

`ifdef PD_ENDIAN_FLIP_EN
  if (MSG_BITS % 32 != 0) begin : g_bad_flip_width
    $error("pd_msg_padder: MSG_BITS must be a multiple of 32 with word flip");
  end
  pd_word_flip #(
    .WORDS (MSG_BITS / 32)
  ) u_word_flip (
    .i_data (msg_data),
    .o_data (w_msg_in)
  );
`else
  assign w_msg_in = msg_data;
`endif

  assign w_start_clamped = (int'(start_block) >= NBLK) ? LAST_IDX : start_block;

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_load       = 1'b0;
    case (r_state)
      PD_IDLE: begin
        if (msg_valid) begin
          w_state_next = PD_EMIT;
          w_idx_next   = w_start_clamped;
          w_load       = 1'b1;
        end
      end
      PD_EMIT: begin
        if (blk_ready) begin
          if (r_idx == LAST_IDX) begin
            w_state_next = PD_IDLE;
            w_idx_next   = '0;
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        w_state_next = PD_IDLE;
        w_idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= PD_IDLE;
      r_idx   <= '0;
      r_msg   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      if (w_load) begin
        r_msg <= w_msg_in;
      end
    end
  end

  // Padded image is built only from registered state; the zero fill comes from widening the length.
  logic [PAD_BITS-1:0]    w_pad;
  logic [PD_BLK_BITS-1:0] w_blocks [NENT];

  assign w_pad = {r_msg, 1'b1, TAIL_W'(64'(MSG_BITS))};

  for (genvar gi = 0; gi < NENT; gi++) begin : g_blk
    if (gi < NBLK) begin : g_real
      assign w_blocks[gi] = w_pad[PAD_BITS-1-PD_BLK_BITS*gi -: PD_BLK_BITS];
    end else begin : g_unused
      assign w_blocks[gi] = '0;
    end
  end

  assign busy      = (r_state == PD_EMIT);
  assign msg_ready = (r_state == PD_IDLE);
  assign blk_valid = busy;
  assign blk_idx   = r_idx;
  assign blk_last  = busy && (r_idx == LAST_IDX);
  assign blk_data  = busy ? w_blocks[r_idx] : '0;

endmodule

// File: tb/tb_pd_msg_padder.sv
// Scoreboard bench for pd_msg_padder: directed messages on several MSG_BITS builds.
module tb_pd_msg_padder;

  logic clk;
  logic rst;
  logic blk_ready;

  logic         v640, r640, bv640, bl640, busy640;
  logic [639:0] d640;
  logic [0:0]   s640, bi640;
  logic [511:0] bd640;

  logic         v960, r960, bv960, bl960, busy960;
  logic [959:0] d960;
  logic [1:0]   s960, bi960;
  logic [511:0] bd960;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int           dut;
    logic [511:0] data;
    int           idx;
    logic         last;
  } exp_t;
  exp_t sb_q[$];

  pd_msg_padder #(.MSG_BITS(640)) u640 (
    .clk(clk), .rst(rst), .msg_valid(v640), .msg_ready(r640), .msg_data(d640),
    .start_block(s640), .blk_valid(bv640), .blk_ready(blk_ready), .blk_data(bd640),
    .blk_idx(bi640), .blk_last(bl640), .busy(busy640)
  );

  pd_msg_padder #(.MSG_BITS(960)) u960 (
    .clk(clk), .rst(rst), .msg_valid(v960), .msg_ready(r960), .msg_data(d960),
    .start_block(s960), .blk_valid(bv960), .blk_ready(blk_ready), .blk_data(bd960),
    .blk_idx(bi960), .blk_last(bl960), .busy(busy960)
  );

`ifndef PD_ENDIAN_FLIP_EN
  logic         v447, r447, bv447, bl447, busy447;
  logic [446:0] d447;
  logic [0:0]   s447, bi447;
  logic [511:0] bd447;

  logic         v448, r448, bv448, bl448, busy448;
  logic [447:0] d448;
  logic [0:0]   s448, bi448;
  logic [511:0] bd448;

  pd_msg_padder #(.MSG_BITS(447)) u447 (
    .clk(clk), .rst(rst), .msg_valid(v447), .msg_ready(r447), .msg_data(d447),
    .start_block(s447), .blk_valid(bv447), .blk_ready(blk_ready), .blk_data(bd447),
    .blk_idx(bi447), .blk_last(bl447), .busy(busy447)
  );

  pd_msg_padder #(.MSG_BITS(448)) u448 (
    .clk(clk), .rst(rst), .msg_valid(v448), .msg_ready(r448), .msg_data(d448),
    .start_block(s448), .blk_valid(bv448), .blk_ready(blk_ready), .blk_data(bd448),
    .blk_idx(bi448), .blk_last(bl448), .busy(busy448)
  );
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ew(input logic [31:0] w);
`ifdef PD_ENDIAN_FLIP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [31:0] word640(input int i, input logic [31:0] w0);
    return (i == 0) ? w0 : 32'(i + 1);
  endfunction

  function automatic logic [639:0] msg640(input logic [31:0] w0);
    logic [639:0] m = '0;
    for (int i = 0; i < 20; i++) m[639-32*i -: 32] = word640(i, w0);
    return m;
  endfunction

  // Hand layout: block 0 = words 1..16; block 1 = words 17..20, '1' at bit 383, length 640.
  function automatic logic [511:0] exp640(input int k, input logic [31:0] w0);
    logic [511:0] b = '0;
    if (k == 0) begin
      for (int i = 0; i < 16; i++) b[511-32*i -: 32] = ew(word640(i, w0));
    end else begin
      for (int i = 0; i < 4; i++) b[511-32*i -: 32] = ew(32'(17 + i));
      b[383]  = 1'b1;
      b[63:0] = 64'h280;
    end
    return b;
  endfunction

  function automatic void push(input int dut, input logic [511:0] data, input int idx, input logic last);
    exp_t e;
    e.dut = dut; e.data = data; e.idx = idx; e.last = last;
    sb_q.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input int dut, input logic [511:0] data, input int idx, input logic last);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_block dut=%0d idx=%0d", dut, idx);
    end else begin
      e = sb_q.pop_front();
      if (e.dut != dut || e.data !== data || e.idx != idx || e.last !== last) begin
        errors++;
        $display("FAIL block dut=%0d/%0d idx=%0d/%0d last=%0b/%0b got=%0h exp=%0h",
                 dut, e.dut, idx, e.idx, last, e.last, data, e.data);
      end else begin
        $display("block dut=%0d idx=%0d last=%0b ok", dut, idx, last);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst && blk_ready) begin
      if (bv640) sb_check(640, bd640, int'(bi640), bl640);
      if (bv960) sb_check(960, bd960, int'(bi960), bl960);
`ifndef PD_ENDIAN_FLIP_EN
      if (bv447) sb_check(447, bd447, int'(bi447), bl447);
      if (bv448) sb_check(448, bd448, int'(bi448), bl448);
`endif
    end
  end

  function automatic logic rdy(input int dut);
    case (dut)
      640: return r640;
      960: return r960;
`ifndef PD_ENDIAN_FLIP_EN
      447: return r447;
      448: return r448;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic vld(input int dut);
    case (dut)
      640: return bv640;
      960: return bv960;
`ifndef PD_ENDIAN_FLIP_EN
      447: return bv447;
      448: return bv448;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Present one message; returns #1 after the accepting edge.
  task automatic send(input int dut, input logic [1023:0] data, input int start);
    int n = 0;
    while (!rdy(dut) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL send_timeout dut=%0d", dut);
    end
    case (dut)
      640: begin d640 = data[639:0]; s640 = 1'(start); v640 = 1'b1; end
      960: begin d960 = data[959:0]; s960 = 2'(start); v960 = 1'b1; end
`ifndef PD_ENDIAN_FLIP_EN
      447: begin d447 = data[446:0]; s447 = 1'(start); v447 = 1'b1; end
      448: begin d448 = data[447:0]; s448 = 1'(start); v448 = 1'b1; end
`endif
      default: ;
    endcase
    @(posedge clk); #1;
    v640 = 1'b0; v960 = 1'b0;
`ifndef PD_ENDIAN_FLIP_EN
    v447 = 1'b0; v448 = 1'b0;
`endif
    chk($sformatf("accept_latency_%0d", dut), 512'(vld(dut)), 512'(1));
  endtask

  logic [639:0] m640;
  logic [447:0] m448;
  logic [446:0] m447;
  logic [511:0] held;

  initial begin
    rst = 1'b1; blk_ready = 1'b0;
    v640 = 1'b0; d640 = '0; s640 = '0;
    v960 = 1'b0; d960 = '0; s960 = '0;
`ifndef PD_ENDIAN_FLIP_EN
    v447 = 1'b0; d447 = '0; s447 = '0;
    v448 = 1'b0; d448 = '0; s448 = '0;
`endif
    @(posedge clk); #1;
    chk("rst_blk_valid", 512'(bv640), 512'(0));
    chk("rst_blk_idx", 512'(bi640), 512'(0));
    chk("rst_blk_last", 512'(bl640), 512'(0));
    chk("rst_busy", 512'(busy640), 512'(0));
    chk("rst_blk_data", bd640, 512'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_msg_ready", 512'(r640), 512'(1));

    // Full two-block message from block 0.
    blk_ready = 1'b1;
    m640 = msg640(32'h1);
    push(640, exp640(0, 32'h1), 0, 1'b0);
    push(640, exp640(1, 32'h1), 1, 1'b1);
    send(640, 1024'(m640), 0);
    chk("a_busy_first", 512'(busy640), 512'(1));
    chk("a_ready_low", 512'(r640), 512'(0));
    @(posedge clk); #1;
    chk("a_idx_second", 512'(bi640), 512'(1));
    @(posedge clk); #1;
    chk("a_ready_after_last", 512'(r640), 512'(1));

    // Start at block 1: a single final block.
    push(640, exp640(1, 32'h1), 1, 1'b1);
    send(640, 1024'(m640), 1);
    chk("b_last", 512'(bl640), 512'(1));
    @(posedge clk); #1;
    chk("b_ready_after", 512'(r640), 512'(1));

    // Clamp: start_block 3 on a 3-block build emits only block 2 = {448'b0, 64'd960}.
    push(960, {448'b0, 64'd960}, 2, 1'b1);
    send(960, 1024'({30{32'hDEADBEEF}}), 3);
    chk("c_clamp_idx", 512'(bi960), 512'(2));
    @(posedge clk); #1;
    chk("c_ready_after", 512'(r960), 512'(1));

    // Backpressure for 5 cycles while msg_data toggles; also carries the word-flip pattern.
    blk_ready = 1'b0;
    m640 = msg640(32'h01234567);
    held = exp640(0, 32'h01234567);
    push(640, held, 0, 1'b0);
    push(640, exp640(1, 32'h01234567), 1, 1'b1);
    send(640, 1024'(m640), 0);
    for (int i = 0; i < 5; i++) begin
      d640 = ~d640;
      @(posedge clk); #1;
      chk("stall_data", bd640, held);
      chk("stall_idx", 512'(bi640), 512'(0));
    end
`ifdef PD_ENDIAN_FLIP_EN
    chk("flip_word0", 512'(bd640[511:480]), 512'(32'h67452301));
`else
    chk("word0", 512'(bd640[511:480]), 512'(32'h01234567));
`endif
    blk_ready = 1'b1;
    @(posedge clk); #1;
    chk("resume_len", 512'(bd640[63:0]), 512'(64'h280));
    @(posedge clk); #1;

    // Asynchronous reset after block 0 has been taken.
    m640 = msg640(32'h1);
    push(640, exp640(0, 32'h1), 0, 1'b0);
    push(640, exp640(1, 32'h1), 1, 1'b1);
    send(640, 1024'(m640), 0);
    @(posedge clk); #1;
    blk_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_blk_valid", 512'(bv640), 512'(0));
    chk("arst_blk_idx", 512'(bi640), 512'(0));
    chk("arst_blk_data", bd640, 512'(0));
    chk("arst_pending", 512'(sb_q.size()), 512'(1));
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    blk_ready = 1'b1;
    push(640, exp640(0, 32'h1), 0, 1'b0);
    push(640, exp640(1, 32'h1), 1, 1'b1);
    send(640, 1024'(m640), 0);
    chk("post_rst_idx", 512'(bi640), 512'(0));

`ifndef PD_ENDIAN_FLIP_EN
    // Boundary builds: 447 fits in one block, 448 spills the length into a second.
    for (int i = 0; i < 14; i++) m448[447-32*i -: 32] = 32'hC0DE0000 | 32'(i);
    m447 = m448[447:1];
    push(447, {m447, 1'b1, 64'd447}, 0, 1'b1);
    send(447, 1024'(m447), 0);
    push(448, {m448, 1'b1, 63'b0}, 0, 1'b0);
    push(448, {448'b0, 64'd448}, 1, 1'b1);
    send(448, 1024'(m448), 0);
`endif

    begin
      int n = 0;
      while (sb_q.size() != 0 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("drain_empty", 512'(sb_q.size()), 512'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pd_msg_padder.md
Name: pd_msg_padder

Overview:
- Sequential successor to the packet decoder's combinational chunk select.
- Accepts one message of MSG_BITS bits through a valid/ready handshake.
- Builds the SHA-256 padded image: message, one '1' bit, zero fill, 64-bit length.
- Streams that image out as consecutive 512-bit blocks to the hash core through a second valid/ready handshake.
- Supports starting mid-message (start_block) so a stored midstate can be reused when only the tail changes, e.g. a nonce sweep.

Parameters:
- MSG_BITS, 640: message length in bits; legal range 1..2^20; must be a multiple of 32 when PD_ENDIAN_FLIP_EN is defined.
- BLK_BITS, 512: block width; fixed for SHA-256; any other value is illegal and fails an elaboration assertion.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- msg_valid  in  1  msg_data/start_block are valid.
- msg_ready  out  1  block can accept a message.
- msg_data  in  MSG_BITS  message; msg_data[MSG_BITS-1] is the first bit hashed.
- start_block  in  IDX_W  index of the first block to emit; IDX_W = max(1, clog2(NBLK)).
- blk_valid  out  1  blk_data valid.
- blk_ready  in  1  hash core accepts block.
- blk_data  out  512  padded block.
- blk_idx  out  IDX_W  index of the current block.
- blk_last  out  1  current block is block NBLK-1.
- busy  out  1  a message is held (state EMIT).

Behaviour:
- NBLK = ceil((MSG_BITS+65)/512). PAD_BITS = NBLK*512.
- Padded image P, PAD_BITS wide: {msg, 1'b1, zeros(PAD_BITS-MSG_BITS-65), 64'(MSG_BITS)}.
- Block k = P[PAD_BITS-1-512k -: 512].
- For MSG_BITS=640: NBLK=2; block 1 = {msg[127:0], 1'b1, 319'b0, 64'd640}.
- States:
  - IDLE: msg_ready=1. On msg_valid, latch msg_data into msg_q, latch idx_q = min(start_block, NBLK-1), go to EMIT.
  - EMIT: blk_valid=1, blk_data = block idx_q of P built from msg_q. On blk_valid&&blk_ready: if idx_q==NBLK-1, go to IDLE; else idx_q += 1.
- Latency: message accepted on edge t means blk_valid is high in the cycle after t. One block per cycle while blk_ready is held high.
- msg_ready is low throughout EMIT. After the last block is accepted, msg_ready is high in the next cycle, so there is at least one idle cycle between messages.
- While blk_valid && !blk_ready: blk_data, blk_idx and blk_last are held stable. msg_data changes are ignored because the message is registered.
- blk_data, blk_idx and blk_last are registered or derived only from registers; no combinational path from msg_* to blk_*.
- start_block >= NBLK is clamped to NBLK-1, so only the final block is emitted.
- NBLK==1 (MSG_BITS<=447): every message emits exactly one block with blk_last=1.
- Reset, asynchronous at any time including mid-EMIT: state=IDLE, idx_q=0, msg_q=0, blk_valid=0, blk_idx=0, blk_last=0, busy=0, blk_data=0, msg_ready=1 once rst is released. A partially emitted message is discarded.
- blk_ready while blk_valid=0 has no effect.

Optional Feature:
- Macro PD_ENDIAN_FLIP_EN.
- Defined: msg_q is loaded with each 32-bit word of msg_data byte-reversed, e.g. 0x01234567 becomes 0x67452301, before padding. The padding bit and length field are never flipped. This matches little-endian Bitcoin header fields.
- Not defined: the message is padded as received.

Decomposition:
- Package pd_pkg holds:
  - PD_BLK_BITS=512 and PD_LEN_BITS=64;
  - functions pd_nblk(msg_bits) and pd_idx_w(nblk);
  - enum pd_pad_state_t {PD_IDLE, PD_EMIT}.
- One sub-module, pd_word_flip: combinational 32-bit-word byte reversal, instantiated only under PD_ENDIAN_FLIP_EN.

Test Plan:
- MSG_BITS=640, msg = 20 words 0x00000001..0x00000014, start_block=0, blk_ready=1:
  - block 0 = words 1..16, idx=0, last=0;
  - next cycle, block 1 = {words 17..20, 1'b1, 319'b0, 64'h280}, idx=1, last=1;
  - msg_ready high one cycle later.
- Same message with start_block=1: only block 1 is emitted, one cycle after acceptance, last=1. With start_block=3: clamped to the same single block 1.
- blk_ready low for 5 cycles after blk_valid rises: blk_data/idx stay constant; msg_data toggles are ignored; output resumes correctly when blk_ready rises.
- MSG_BITS=447 and MSG_BITS=448 builds:
  - 447: one block ending {1'b1, 64'd447}, last=1;
  - 448: two blocks; block 0 = {msg, 1'b1, 63'b0}; block 1 = {448'b0, 64'd448}.
- rst asserted mid-EMIT after block 0: blk_valid drops asynchronously, idx=0. A new message after reset starts again at block 0.
- PD_ENDIAN_FLIP_EN defined, word 0 = 0x01234567: blk_data[511:480] = 0x67452301; the length field is still 64'h280.
